// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM encodings, scoreboard
// entry layout and the register-match helper used by the scoreboard.
package hazard_ctrl_unit_pkg;

  localparam int          REG_W    = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic [REG_W-1:0] dest;
    logic             mem_read;
  } sb_entry_t;

  // R0 is hardwired, so a write to it never creates a dependency.
  function automatic logic entry_match(input sb_entry_t e, input logic [REG_W-1:0] src);
    return e.valid & e.wb_en & (e.dest == src) & (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_scoreboard.sv
// Shadow scoreboard of in-flight register writes (entry0=EX .. entry DEPTH-1=WB)
// with RAW match against the decode-stage sources.
module hazard_scoreboard
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int FORWARD = 0,
  parameter int DEPTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  input  sb_entry_t        i_new,
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_src1,
  input  logic [REG_W-1:0] i_src2,
  input  logic             i_use_src2,
  output logic             o_hazard
);

  sb_entry_t r_entry [DEPTH];
  logic      w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else if (i_advance) begin
      r_entry[0] <= i_new;
      for (int i = 1; i < DEPTH; i++) r_entry[i] <= r_entry[i-1];
    end
  end

  // Without forwarding, WB is excluded because the regfile writes in the first half.
  always_comb begin
    w_hit = 1'b0;
    if (FORWARD == 0) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (entry_match(r_entry[k], i_src1) ||
            (i_use_src2 && entry_match(r_entry[k], i_src2)))
          w_hit = 1'b1;
      end
    end else begin
      if (r_entry[0].mem_read &&
          (entry_match(r_entry[0], i_src1) ||
           (i_use_src2 && entry_match(r_entry[0], i_src2))))
        w_hit = 1'b1;
    end
  end

  assign o_hazard = i_id_valid & w_hit;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: stall/bubble/flush/freeze generation for IF/ID/EX
// plus a saturating stall-cycle counter.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int FORWARD = 0,
  parameter int DEPTH   = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_src1,
  input  logic [4:0]       i_id_src2,
  input  logic             i_id_use_src2,
  input  logic             i_id_wb_en,
  input  logic [4:0]       i_id_dest,
  input  logic             i_id_mem_read,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_busy,
  output logic             o_hold_if_id,
  output logic             o_bubble_id_ex,
  output logic             o_flush_if_id,
  output logic             o_freeze_all,
  output logic [CNT_W-1:0] o_stall_cnt
);

  state_t            r_state;
  state_t            w_mode;
  logic              r_br_pend;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hazard;
  logic              w_issue;
  sb_entry_t         w_new;

  hazard_scoreboard #(.FORWARD(FORWARD), .DEPTH(DEPTH)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_advance  (~o_freeze_all),
    .i_new      (w_new),
    .i_id_valid (i_id_valid),
    .i_src1     (i_id_src1),
    .i_src2     (i_id_src2),
    .i_use_src2 (i_id_use_src2),
    .o_hazard   (w_hazard)
  );

  // Mode of the current cycle; the register only remembers it for freeze exit.
  always_comb begin
    w_mode = ST_RUN;
    if (i_mem_busy)
      w_mode = ST_FREEZE;
    else if (i_ex_br_taken || (r_state == ST_FREEZE && r_br_pend))
      w_mode = ST_FLUSH;
    else if (w_hazard)
      w_mode = ST_STALL;
  end

  assign o_hold_if_id   = (w_mode == ST_STALL);
  assign o_bubble_id_ex = (w_mode == ST_STALL) || (w_mode == ST_FLUSH);
  assign o_flush_if_id  = (w_mode == ST_FLUSH);
  assign o_freeze_all   = (w_mode == ST_FREEZE);
  assign o_stall_cnt    = r_cnt;

  assign w_issue = i_id_valid & ~o_hold_if_id & ~o_flush_if_id & ~o_freeze_all;

  always_comb begin
    w_new = '0;
    if (w_issue) begin
      w_new.valid    = 1'b1;
      w_new.wb_en    = i_id_wb_en;
      w_new.dest     = i_id_dest;
      w_new.mem_read = i_id_mem_read;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_br_pend <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_mode;
      r_br_pend <= (w_mode == ST_FREEZE) ? (r_br_pend | i_ex_br_taken) : 1'b0;
      if ((o_hold_if_id || o_freeze_all) && !(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
